// File: rtl/des_pkg.sv
// Shared types and constants for the serial word deserializer.
package des_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        STOP = 2'b10
    } state_t;

    localparam logic [1:0] MODE_RAW    = 2'b00;
    localparam logic [1:0] MODE_FRAMED = 2'b01;
    localparam logic [1:0] MODE_FLUSH  = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

endpackage

// File: rtl/des_cond.sv
// Serial-to-parallel word assembler with raw and start/stop framed modes,
// a one-deep output register with valid/ack handshake and sticky error flags.
module des_cond
    import des_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enb,
    input  logic             dir,
    input  logic             s_in,
    input  logic [1:0]       mode,
    input  logic             ack,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             busy,
    output logic             frm_err,
    output logic             ovr_err
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] word_q;
    logic             modeFramed_q;
    logic             dirLsb_q;
    logic             valid_q;
    logic             frmErr_q;
    logic             ovrErr_q;

    logic             active_d;
    logic             flush_d;
    logic             step_d;
    logic             dirSel_d;
    logic [WIDTH-1:0] shiftIn_d;
    logic             deliver_d;
    logic [WIDTH-1:0] deliverWord_d;

    // In IDLE the word has not started yet, so the live dir input decides the
    // placement of the first raw bit; afterwards the latched order is used.
    always_comb begin
        active_d      = enb && (mode != MODE_HOLD);
        flush_d       = active_d && (mode == MODE_FLUSH);
        step_d        = active_d && !flush_d;
        dirSel_d      = (state_q == IDLE) ? dir : dirLsb_q;
        shiftIn_d     = dirSel_d ? {s_in, shift_q[WIDTH-1:1]}
                                 : {shift_q[WIDTH-2:0], s_in};
        deliver_d     = step_d &&
                        (((state_q == DATA) && (count_q == LAST_BIT) && !modeFramed_q) ||
                         ((state_q == STOP) && !s_in));
        deliverWord_d = (state_q == STOP) ? shift_q : shiftIn_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            modeFramed_q <= 1'b0;
            dirLsb_q     <= 1'b0;
            valid_q      <= 1'b0;
            frmErr_q     <= 1'b0;
            ovrErr_q     <= 1'b0;
        end else begin
            if (flush_d) begin
                state_q  <= IDLE;
                count_q  <= '0;
                shift_q  <= '0;
                frmErr_q <= 1'b0;
                ovrErr_q <= 1'b0;
            end else if (step_d) begin
                case (state_q)
                    IDLE: begin
                        if (mode == MODE_RAW) begin
                            shift_q      <= shiftIn_d;
                            count_q      <= CW'(1);
                            modeFramed_q <= 1'b0;
                            dirLsb_q     <= dir;
                            state_q      <= DATA;
                        end else if (s_in) begin
                            count_q      <= '0;
                            modeFramed_q <= 1'b1;
                            dirLsb_q     <= dir;
                            state_q      <= DATA;
                        end
                    end
                    DATA: begin
                        shift_q <= shiftIn_d;
                        count_q <= count_q + CW'(1);
                        if (count_q == LAST_BIT) begin
                            state_q <= modeFramed_q ? STOP : IDLE;
                        end
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (s_in) begin
                            frmErr_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end

            // A delivery into a full register only lands if the consumer is
            // taking the old word on this very edge; otherwise it is lost.
            if (deliver_d) begin
                if (!valid_q || ack) begin
                    word_q  <= deliverWord_d;
                    valid_q <= 1'b1;
                end else begin
                    ovrErr_q <= 1'b1;
                end
            end else if (ack) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign q       = word_q;
    assign valid   = valid_q;
    assign busy    = (state_q != IDLE);
    assign frm_err = frmErr_q;
    assign ovr_err = ovrErr_q;

endmodule

// File: tb/tb_des_cond.sv
// Directed self-checking bench for des_cond (WIDTH=4) with hand-computed
// expected words, handshake, error-flag, flush and reset scenarios.
module tb_des_cond;
    import des_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       enb;
    logic       dir;
    logic       s_in;
    logic [1:0] mode;
    logic       ack;
    logic [3:0] q;
    logic       valid;
    logic       busy;
    logic       frm_err;
    logic       ovr_err;

    int errors = 0;
    int checks = 0;

    des_cond #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enb     (enb),
        .dir     (dir),
        .s_in    (s_in),
        .mode    (mode),
        .ack     (ack),
        .q       (q),
        .valid   (valid),
        .busy    (busy),
        .frm_err (frm_err),
        .ovr_err (ovr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the edge happen, settle 1 time unit after it.
    task automatic applyStimulus(input logic e, input logic d, input logic s,
                                 input logic [1:0] m, input logic a);
        enb  = e;
        dir  = d;
        s_in = s;
        mode = m;
        ack  = a;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expQ,
                               input logic expValid, input logic expBusy,
                               input logic expFrm, input logic expOvr);
        checks++;
        assert (q === expQ) else begin
            errors++;
            $error("[TB] FAIL %s q: got %b expected %b", tag, q, expQ);
        end
        checks++;
        assert (valid === expValid) else begin
            errors++;
            $error("[TB] FAIL %s valid: got %b expected %b", tag, valid, expValid);
        end
        checks++;
        assert (busy === expBusy) else begin
            errors++;
            $error("[TB] FAIL %s busy: got %b expected %b", tag, busy, expBusy);
        end
        checks++;
        assert (frm_err === expFrm) else begin
            errors++;
            $error("[TB] FAIL %s frm_err: got %b expected %b", tag, frm_err, expFrm);
        end
        checks++;
        assert (ovr_err === expOvr) else begin
            errors++;
            $error("[TB] FAIL %s ovr_err: got %b expected %b", tag, ovr_err, expOvr);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, MODE_RAW, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, MODE_RAW, 1'b0);
        checkOutput("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Raw, MSB first, with an idle strobe gap inside the word.
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_RAW, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, MODE_RAW, 1'b0);
        checkOutput("raw0_gap", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, MODE_RAW, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_RAW, 1'b0);
        checkOutput("raw0_bit3", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_RAW, 1'b0);
        checkOutput("raw0_word", 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, MODE_RAW, 1'b1);
        checkOutput("raw0_ack", 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);

        // Raw, LSB first; later bits present dir=0 and a hold cycle, both ignored.
        applyStimulus(1'b1, 1'b1, 1'b1, MODE_RAW, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, MODE_RAW, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, MODE_HOLD, 1'b0);
        checkOutput("raw1_hold", 4'b1011, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_RAW, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_RAW, 1'b0);
        checkOutput("raw1_word", 4'b1101, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, MODE_RAW, 1'b1);
        checkOutput("raw1_ack", 4'b1101, 1'b0, 1'b0, 1'b0, 1'b0);

        // Framed: idle zero ignored, start, data 0110, good stop.
        applyStimulus(1'b1, 1'b0, 1'b0, MODE_FRAMED, 1'b0);
        checkOutput("frm_idle0", 4'b1101, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_FRAMED, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, MODE_FRAMED, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_FRAMED, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_FRAMED, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, MODE_FRAMED, 1'b0);
        checkOutput("frm_stopwait", 4'b1101, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, MODE_FRAMED, 1'b0);
        checkOutput("frm_word", 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, MODE_FRAMED, 1'b1);

        // Framed with bad stop bit: word discarded, frm_err raised.
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_FRAMED, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, MODE_FRAMED, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_FRAMED, 1'b0);
        checkOutput("frm_badstop", 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, MODE_FLUSH, 1'b0);
        checkOutput("frm_flush", 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);

        // Overrun: second word lost without ack.
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_RAW, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, MODE_RAW, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_RAW, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, MODE_RAW, 1'b0);
        checkOutput("ovr_first", 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, MODE_RAW, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_RAW, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, MODE_RAW, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_RAW, 1'b0);
        checkOutput("ovr_lost", 4'b1010, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, MODE_FLUSH, 1'b0);
        checkOutput("ovr_flush", 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0);

        // Delivery while full but acked on the same edge replaces the word.
        applyStimulus(1'b1, 1'b0, 1'b0, MODE_RAW, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_RAW, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, MODE_RAW, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_RAW, 1'b1);
        checkOutput("ovr_ackswap", 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, MODE_RAW, 1'b1);
        checkOutput("ovr_ack", 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);

        // Flush mid-word, then a fresh word; mode change mid-word is ignored.
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_RAW, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_RAW, 1'b0);
        checkOutput("fl_mid", 4'b0101, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_FLUSH, 1'b0);
        checkOutput("fl_flush", 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, MODE_RAW, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, MODE_FRAMED, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_FRAMED, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_FRAMED, 1'b0);
        checkOutput("fl_word", 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset mid-word overrides everything; next edges build a fresh word.
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_RAW, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_RAW, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_RAW, 1'b0);
        checkOutput("rst_pre", 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_RAW, 1'b1);
        checkOutput("rst_mid", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_RAW, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, MODE_RAW, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, MODE_RAW, 1'b0);
        checkOutput("rst_partial", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, MODE_RAW, 1'b0);
        checkOutput("rst_fresh", 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
